quantum_watchdog: RTL and testbench

//  Preemption timer feeding reset_controller: owns output_watchdog (remaining time

---
 rtl/quantum_watchdog.sv | 113 +++++++++++
 tb/tb_quantum_watchdog.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/quantum_watchdog.sv
// quantum_watchdog: preemption timer for the reset_controller.
// The OS arms it with a time quantum. It counts down only while user code runs
// (program_counter >= OS_LIMIT) and the pipeline is not stalled. At expiry it
// raises context_exchange and holds it until the CPU acknowledges the jump.
// output_watchdog == 0 means the timer is disarmed.
// Both outputs come straight from flops, so there is no input-to-output
// combinational path.

`timescale 1ns/1ps

module quantum_watchdog #(
    parameter int          WD_WIDTH  = 32,
    parameter int          PC_WIDTH  = 12,
    parameter int          OS_LIMIT  = 256,
    parameter logic [5:0]  OP_SETWD  = 6'b101000,
    parameter logic [5:0]  OP_STOPWD = 6'b101001,
    parameter logic [5:0]  OP_START  = 6'b100111
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [5:0]          operation,
    input  logic [WD_WIDTH-1:0] wd_value,
    input  logic [PC_WIDTH-1:0] program_counter,
    input  logic                halt,
    input  logic                resume_os,
    input  logic                context_ack,
    output logic [WD_WIDTH-1:0] output_watchdog,
    output logic                context_exchange
);

    typedef enum logic [1:0] {
        ST_IDLE,     // disarmed, count == 0
        ST_COUNT,    // armed, counting down toward 1
        ST_EXPIRED   // quantum used up, jump requested, count parked at 1
    } state_t;

    localparam logic [PC_WIDTH-1:0] OS_LIMIT_PC = PC_WIDTH'(OS_LIMIT);
    localparam logic [WD_WIDTH-1:0] ONE         = WD_WIDTH'(1);

    state_t              state;
    logic [WD_WIDTH-1:0] count;
    logic [WD_WIDTH-1:0] quantum;
    logic                ctx_req;
    logic                user_code;
    logic                count_enable;

    // A counting edge is one where user code executes and the pipeline advances.
    assign user_code    = (program_counter >= OS_LIMIT_PC);
    assign count_enable = user_code && !halt;

    // Command decode and countdown. The if/else chain encodes the command
    // priority, so lower-priority events in the same cycle are simply dropped.
    // NOTE: every register here uses non-blocking assignment so that all of them
    // update together from the values present before the edge.
    always_ff @(posedge clock) begin
        if (reset || (operation == OP_START)) begin
            state   <= ST_IDLE;
            count   <= '0;
            quantum <= '0;
            ctx_req <= 1'b0;
        end else if (operation == OP_STOPWD) begin
            // Disarm, but keep the stored quantum so resume_os can re-arm later.
            state   <= ST_IDLE;
            count   <= '0;
            ctx_req <= 1'b0;
        end else if (operation == OP_SETWD) begin
            // A zero quantum is a disarm. From EXPIRED this also drops the
            // pending request.
            quantum <= wd_value;
            count   <= wd_value;
            ctx_req <= 1'b0;
            state   <= (wd_value == '0) ? ST_IDLE : ST_COUNT;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (resume_os && (quantum != '0)) begin
                        state <= ST_COUNT;
                        count <= quantum;
                    end
                end
                ST_COUNT: begin
                    // The count never goes below 1. Reaching 1 and then counting
                    // once more is what causes the expiry.
                    if (count_enable) begin
                        if (count > ONE) begin
                            count <= count - ONE;
                        end else begin
                            state   <= ST_EXPIRED;
                            ctx_req <= 1'b1;
                        end
                    end
                end
                ST_EXPIRED: begin
                    // A resume_os in the same cycle as the ack is dropped.
                    if (context_ack) begin
                        state   <= ST_IDLE;
                        count   <= '0;
                        ctx_req <= 1'b0;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    count   <= '0;
                    ctx_req <= 1'b0;
                end
            endcase
        end
    end

    assign output_watchdog  = count;
    assign context_exchange = ctx_req;

endmodule

// File: tb/tb_quantum_watchdog.sv
// Directed self-checking bench for quantum_watchdog.
// Inputs change 1 ns after a rising edge, and outputs are sampled at that same point.

`timescale 1ns/1ps

module tb_quantum_watchdog;

    localparam logic [5:0] OP_NOP    = 6'b000000;
    localparam logic [5:0] OP_SETWD  = 6'b101000;
    localparam logic [5:0] OP_STOPWD = 6'b101001;
    localparam logic [5:0] OP_START  = 6'b100111;

    logic        clock = 1'b0;
    logic        reset;
    logic [5:0]  operation;
    logic [31:0] wd_value;
    logic [11:0] program_counter;
    logic        halt;
    logic        resume_os;
    logic        context_ack;
    logic [31:0] output_watchdog;
    logic        context_exchange;

    int checks   = 0;
    int failures = 0;

    quantum_watchdog dut (
        .clock            (clock),
        .reset            (reset),
        .operation        (operation),
        .wd_value         (wd_value),
        .program_counter  (program_counter),
        .halt             (halt),
        .resume_os        (resume_os),
        .context_ack      (context_ack),
        .output_watchdog  (output_watchdog),
        .context_exchange (context_exchange)
    );

    always #5 clock = ~clock;

    // Advance one rising edge and settle 1 ns past it.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Apply a one-cycle command, then return the inputs to their quiet values.
    task automatic cmd(input logic [5:0] op, input logic [31:0] val);
        operation = op;
        wd_value  = val;
        tick();
        operation = OP_NOP;
        wd_value  = '0;
    endtask

    task automatic pulse_resume();
        resume_os = 1'b1;
        tick();
        resume_os = 1'b0;
    endtask

    task automatic pulse_ack();
        context_ack = 1'b1;
        tick();
        context_ack = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (output_watchdog !== 32'd0 || context_exchange !== 1'b0) begin
            failures++;
            $display("FAIL reset_init got wd=%0d cx=%0b want wd=0 cx=0", output_watchdog, context_exchange);
        end
        cmd(OP_SETWD, 32'd40);
        repeat (3) tick();
        checks++;
        if (output_watchdog !== 32'd37) begin
            failures++;
            $display("FAIL reset_precount got wd=%0d want 37", output_watchdog);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (output_watchdog !== 32'd0 || context_exchange !== 1'b0) begin
            failures++;
            $display("FAIL reset_midcount got wd=%0d cx=%0b want wd=0 cx=0", output_watchdog, context_exchange);
        end
        pulse_resume();
        tick();
        checks++;
        if (output_watchdog !== 32'd0) begin
            failures++;
            $display("FAIL reset_resume_ignored got wd=%0d want 0", output_watchdog);
        end
    endtask

    task automatic test_expiry();
        cmd(OP_SETWD, 32'd5);
        for (int i = 5; i >= 1; i--) begin
            checks++;
            if (output_watchdog !== 32'(i) || context_exchange !== 1'b0) begin
                failures++;
                $display("FAIL expiry_count got wd=%0d cx=%0b want wd=%0d cx=0", output_watchdog, context_exchange, i);
            end
            if (i > 1) tick();
        end
        for (int i = 0; i < 11; i++) begin
            tick();
            checks++;
            if (output_watchdog !== 32'd1 || context_exchange !== 1'b1) begin
                failures++;
                $display("FAIL expiry_hold[%0d] got wd=%0d cx=%0b want wd=1 cx=1", i, output_watchdog, context_exchange);
            end
        end
        pulse_ack();
        checks++;
        if (output_watchdog !== 32'd0 || context_exchange !== 1'b0) begin
            failures++;
            $display("FAIL expiry_ack got wd=%0d cx=%0b want wd=0 cx=0", output_watchdog, context_exchange);
        end
    endtask

    task automatic test_resume();
        pulse_resume();
        checks++;
        if (output_watchdog !== 32'd5 || context_exchange !== 1'b0) begin
            failures++;
            $display("FAIL resume_reload got wd=%0d cx=%0b want wd=5 cx=0", output_watchdog, context_exchange);
        end
        tick();
        tick();
        checks++;
        if (output_watchdog !== 32'd3) begin
            failures++;
            $display("FAIL resume_countdown got wd=%0d want 3", output_watchdog);
        end
        cmd(OP_STOPWD, 32'd0);
        tick();
        checks++;
        if (output_watchdog !== 32'd0 || context_exchange !== 1'b0) begin
            failures++;
            $display("FAIL resume_stop got wd=%0d cx=%0b want wd=0 cx=0", output_watchdog, context_exchange);
        end
        pulse_resume();
        checks++;
        if (output_watchdog !== 32'd5) begin
            failures++;
            $display("FAIL resume_again got wd=%0d want 5", output_watchdog);
        end
        cmd(OP_STOPWD, 32'd0);
    endtask

    // Count gating by PC region (including the 255/256 boundary) and by halt.
    task automatic test_gating();
        logic [11:0] pc_v [9]  = '{12'd100, 12'd300, 12'd300, 12'd100, 12'd300,
                                   12'd256, 12'd255, 12'd300, 12'd300};
        logic        h_v  [9]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [31:0] wd_e [9]  = '{32'd4, 32'd3, 32'd3, 32'd3, 32'd2, 32'd1, 32'd1, 32'd1, 32'd1};
        logic        cx_e [9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        cmd(OP_SETWD, 32'd4);
        for (int i = 0; i < 9; i++) begin
            program_counter = pc_v[i];
            halt            = h_v[i];
            tick();
            checks++;
            if (output_watchdog !== wd_e[i] || context_exchange !== cx_e[i]) begin
                failures++;
                $display("FAIL gating[%0d] got wd=%0d cx=%0b want wd=%0d cx=%0b",
                         i, output_watchdog, context_exchange, wd_e[i], cx_e[i]);
            end
        end
        program_counter = 12'd300;
        halt            = 1'b0;
        pulse_ack();
    endtask

    task automatic test_setwd_in_expired();
        cmd(OP_SETWD, 32'd1);
        tick();
        checks++;
        if (output_watchdog !== 32'd1 || context_exchange !== 1'b1) begin
            failures++;
            $display("FAIL q1_expiry got wd=%0d cx=%0b want wd=1 cx=1", output_watchdog, context_exchange);
        end
        context_ack = 1'b1;
        cmd(OP_SETWD, 32'd8);
        context_ack = 1'b0;
        checks++;
        if (output_watchdog !== 32'd8 || context_exchange !== 1'b0) begin
            failures++;
            $display("FAIL setwd_over_ack got wd=%0d cx=%0b want wd=8 cx=0", output_watchdog, context_exchange);
        end
        tick();
        checks++;
        if (output_watchdog !== 32'd7) begin
            failures++;
            $display("FAIL setwd_counting got wd=%0d want 7", output_watchdog);
        end
        cmd(OP_SETWD, 32'd0);
        checks++;
        if (output_watchdog !== 32'd0 || context_exchange !== 1'b0) begin
            failures++;
            $display("FAIL setwd_zero got wd=%0d cx=%0b want wd=0 cx=0", output_watchdog, context_exchange);
        end
        pulse_resume();
        checks++;
        if (output_watchdog !== 32'd0) begin
            failures++;
            $display("FAIL setwd_zero_resume got wd=%0d want 0", output_watchdog);
        end
    endtask

    task automatic test_start();
        cmd(OP_SETWD, 32'd3);
        operation   = OP_START;
        halt        = 1'b1;
        context_ack = 1'b1;
        #2;
        checks++;
        if (output_watchdog !== 32'd3 || context_exchange !== 1'b0) begin
            failures++;
            $display("FAIL start_no_comb_path got wd=%0d cx=%0b want wd=3 cx=0", output_watchdog, context_exchange);
        end
        operation   = OP_NOP;
        halt        = 1'b0;
        context_ack = 1'b0;
        cmd(OP_SETWD, 32'd1);
        tick();
        checks++;
        if (context_exchange !== 1'b1) begin
            failures++;
            $display("FAIL start_pre_expired got cx=%0b want 1", context_exchange);
        end
        cmd(OP_START, 32'd0);
        checks++;
        if (output_watchdog !== 32'd0 || context_exchange !== 1'b0) begin
            failures++;
            $display("FAIL start_clear got wd=%0d cx=%0b want wd=0 cx=0", output_watchdog, context_exchange);
        end
        pulse_resume();
        checks++;
        if (output_watchdog !== 32'd0) begin
            failures++;
            $display("FAIL start_quantum_cleared got wd=%0d want 0", output_watchdog);
        end
    endtask

    task automatic test_back_to_back();
        cmd(OP_SETWD, 32'd6);
        pulse_resume();
        checks++;
        if (output_watchdog !== 32'd5) begin
            failures++;
            $display("FAIL b2b_resume_in_count got wd=%0d want 5", output_watchdog);
        end
        pulse_ack();
        checks++;
        if (output_watchdog !== 32'd4) begin
            failures++;
            $display("FAIL b2b_ack_in_count got wd=%0d want 4", output_watchdog);
        end
        cmd(OP_SETWD, 32'd2);
        tick();
        tick();
        checks++;
        if (output_watchdog !== 32'd1 || context_exchange !== 1'b1) begin
            failures++;
            $display("FAIL b2b_expired got wd=%0d cx=%0b want wd=1 cx=1", output_watchdog, context_exchange);
        end
        context_ack = 1'b1;
        resume_os   = 1'b1;
        tick();
        context_ack = 1'b0;
        resume_os   = 1'b0;
        checks++;
        if (output_watchdog !== 32'd0 || context_exchange !== 1'b0) begin
            failures++;
            $display("FAIL b2b_ack_resume got wd=%0d cx=%0b want wd=0 cx=0", output_watchdog, context_exchange);
        end
        pulse_resume();
        checks++;
        if (output_watchdog !== 32'd2) begin
            failures++;
            $display("FAIL b2b_resume_after got wd=%0d want 2", output_watchdog);
        end
        reset = 1'b1;
        cmd(OP_SETWD, 32'd9);
        reset = 1'b0;
        checks++;
        if (output_watchdog !== 32'd0 || context_exchange !== 1'b0) begin
            failures++;
            $display("FAIL b2b_reset_over_setwd got wd=%0d cx=%0b want wd=0 cx=0", output_watchdog, context_exchange);
        end
    endtask

    initial begin
        reset           = 1'b0;
        operation       = OP_NOP;
        wd_value        = '0;
        program_counter = 12'd300;
        halt            = 1'b0;
        resume_os       = 1'b0;
        context_ack     = 1'b0;
        tick();
        test_reset();
        test_expiry();
        test_resume();
        test_gating();
        test_setwd_in_expired();
        test_start();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
